// File: rtl/mycpu_div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Returns {remainder, quotient}; stalls the pipeline while a divide is in flight.
//
// state   | meaning
// S_IDLE  | waiting for start_i; outputs cleared
// S_ON    | one quotient bit per clock, MSB first
// S_DZERO | divisor was zero; result forced to 0
// S_END   | result valid, held while start_i stays high
module mycpu_div #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_DZERO, S_END} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic               sgn_q;
  logic               s1_q;
  logic               s2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0] mag1_d;
  logic [WIDTH-1:0] mag2_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             trial_neg_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic [WIDTH-1:0] quo_fix_d;

  always_comb begin
    mag1_d = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2_d = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Dividend bits stream out of dvd_q's MSB while quotient bits fill its LSB.
    shifted_d   = {rem_q, dvd_q[WIDTH-1]};
    trial_d     = shifted_d - {1'b0, dsr_q};
    trial_neg_d = trial_d[WIDTH];
    rem_d       = trial_neg_d ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d       = {dvd_q[WIDTH-2:0], ~trial_neg_d};

    quo_fix_d = (sgn_q && (s1_q ^ s2_q)) ? (~quo_d + 1'b1) : quo_d;
    rem_fix_d = (sgn_q && s1_q) ? (~rem_d + 1'b1) : rem_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            cnt_q <= '0;
            rem_q <= '0;
            sgn_q <= signed_i;
            s1_q  <= opdata1_i[WIDTH-1];
            s2_q  <= opdata2_i[WIDTH-1];
            if (opdata2_i == '0) begin
              dvd_q   <= '0;
              dsr_q   <= '0;
              state_q <= S_DZERO;
            end else begin
              dvd_q   <= mag1_d;
              dsr_q   <= mag2_d;
              state_q <= S_ON;
            end
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q  <= S_END;
              ready_q  <= 1'b1;
              result_q <= {rem_fix_d, quo_fix_d};
            end
          end
        end
        S_DZERO: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_END;
            ready_q  <= 1'b1;
            result_q <= '0;
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_mycpu_div.sv
// Directed bench for mycpu_div: a 32-bit and an 8-bit instance with
// hand-computed quotient/remainder, latency and stall-window expectations.
module tb_mycpu_div;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic        start32 = 1'b0, sg32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        ready32, stall32;

  logic        start8 = 1'b0, sg8 = 1'b0, annul8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        ready8, stall8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mycpu_div #(.WIDTH(32)) u_div32 (
    .clk(clk), .resetn(resetn), .start_i(start32), .signed_i(sg32),
    .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
    .result_o(res32), .ready_o(ready32), .stallreq_o(stall32)
  );

  mycpu_div #(.WIDTH(8)) u_div8 (
    .clk(clk), .resetn(resetn), .start_i(start8), .signed_i(sg8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
    .result_o(res8), .ready_o(ready8), .stallreq_o(stall8)
  );

  // Cycle 0 is the cycle start is raised; lat is the cycle index where ready is first seen.
  task automatic run32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat, output int stalls);
    lat = -1; stalls = 0; res = '0;
    @(negedge clk);
    start32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall32) stalls++;
      if (ready32) begin lat = i; res = res32; break; end
      @(negedge clk);
      if (i == 0) begin a32 = $urandom; b32 = $urandom; sg32 = ~sg; end
    end
  endtask

  task automatic drop32(input string name);
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (ready32 !== 1'b0 || res32 !== 64'd0) begin
      n_fail++;
      $display("FAIL %s_clear: ready=%b result=%h, required ready=0 result=0", name, ready32, res32);
    end
  endtask

  task automatic check32(input string name, input logic [63:0] res, input logic [63:0] exp_res,
                         input int lat, input int exp_lat);
    n_checks++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result: got %h, required %h", name, res, exp_res);
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic watch_no_ready32(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      if (ready32) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL %s: ready seen %0d cycles, required 0", name, seen);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (ready32 !== 1'b0 || res32 !== 64'd0 || stall32 !== 1'b0 || ready8 !== 1'b0 || res8 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready32=%b res32=%h stall32=%b ready8=%b res8=%h, required all 0",
               ready32, res32, stall32, ready8, res8);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic [63:0] r; int lat, st;
    run32(1'b0, 32'd100, 32'd7, r, lat, st);
    check32("divu_100_7", r, {32'd2, 32'd14}, lat, 33);
    n_checks++;
    if (st !== 33) begin
      n_fail++;
      $display("FAIL divu_stall_cycles: got %0d, required 33", st);
    end
    drop32("divu_100_7");
    run32(1'b0, 32'hFFFFFFFF, 32'd1, r, lat, st);
    check32("divu_max_1", r, {32'd0, 32'hFFFFFFFF}, lat, 33);
    drop32("divu_max_1");
  endtask

  task automatic test_div_signed;
    logic [63:0] r; int lat, st;
    run32(1'b1, 32'hFFFFFFF9, 32'd2, r, lat, st);
    check32("div_m7_2", r, {32'hFFFFFFFF, 32'hFFFFFFFD}, lat, 33);
    drop32("div_m7_2");
    run32(1'b1, 32'd7, 32'hFFFFFFFE, r, lat, st);
    check32("div_7_m2", r, {32'h00000001, 32'hFFFFFFFD}, lat, 33);
    drop32("div_7_m2");
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, r, lat, st);
    check32("div_overflow", r, {32'd0, 32'h80000000}, lat, 33);
    drop32("div_overflow");
  endtask

  task automatic test_divzero;
    logic [63:0] r; int lat, st;
    run32(1'b0, 32'h1234, 32'd0, r, lat, st);
    check32("divzero", r, 64'd0, lat, 2);
    drop32("divzero");
  endtask

  task automatic test_annul;
    logic [63:0] r; int lat, st;
    @(negedge clk);
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    for (int i = 0; i < 10; i++) @(negedge clk);
    annul32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    annul32 = 1'b0;
    watch_no_ready32("annul_on_no_ready", 40);
    run32(1'b0, 32'd50, 32'd5, r, lat, st);
    check32("after_annul_50_5", r, {32'd0, 32'd10}, lat, 33);
    drop32("after_annul_50_5");
    @(negedge clk);
    start32 = 1'b1; annul32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0; annul32 = 1'b0;
    watch_no_ready32("start_with_annul_ignored", 40);
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat, st;
    @(negedge clk);
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd50; b32 = 32'd5;
    for (int i = 0; i < 5; i++) @(negedge clk);
    resetn = 1'b0; start32 = 1'b0;
    #1;
    n_checks++;
    if (ready32 !== 1'b0 || res32 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_in_on: ready=%b result=%h, required 0/0", ready32, res32);
    end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    watch_no_ready32("reset_in_on_no_ready", 40);
    run32(1'b0, 32'd100, 32'd7, r, lat, st);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (ready32 !== 1'b0 || res32 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_in_end_async: ready=%b result=%h, required 0/0", ready32, res32);
    end
    start32 = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output int lat);
    lat = -1; res = '0;
    @(negedge clk);
    start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready8) begin lat = i; res = res8; break; end
      @(negedge clk);
      if (i == 0) begin a8 = 8'h5A; b8 = 8'h03; end
    end
  endtask

  task automatic test_width8;
    logic [15:0] r; int lat; int bad;
    run8(1'b0, 8'd200, 8'd13, r, lat);
    n_checks++;
    if (r !== {8'd5, 8'd15} || lat !== 9) begin
      n_fail++;
      $display("FAIL w8_divu_200_13: result=%h lat=%0d, required 050f lat=9", r, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (res8 !== {8'd5, 8'd15} || ready8 !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL w8_hold_in_end: %0d unstable cycles, required 0", bad);
    end
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (ready8 !== 1'b0 || res8 !== 16'd0) begin
      n_fail++;
      $display("FAIL w8_clear: ready=%b result=%h, required 0/0", ready8, res8);
    end
    run8(1'b1, 8'h80, 8'hFF, r, lat);
    n_checks++;
    if (r !== {8'h00, 8'h80} || lat !== 9) begin
      n_fail++;
      $display("FAIL w8_div_overflow: result=%h lat=%0d, required 0080 lat=9", r, lat);
    end
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_div_signed;
    test_divzero;
    test_annul;
    test_reset_mid;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
